clog2_seq_unit: RTL and testbench
=================================

Name: clog2_seq_unit

Overview:
- Sequential ceil-log2 engine for run-time bit-width and address sizing in the SGM pipeline, e.g. disparity range and line-buffer depth.
- Works opposite to a shift-right clog2 function: it starts from a power of two at 1 and doubles it until it covers the input value.
- Returns the exponent, the rounded-up power of two, and an exact-power flag.
- Uses valid/ready handshakes on both sides. Handles one operation at a time.

Parameters:
DATA_WIDTH, 9, width of the input operand (range 0..2^DATA_WIDTH-1).
LOG_WIDTH, 4, width of the exponent output. Must satisfy 2^LOG_WIDTH > DATA_WIDTH.

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand valid
in_ready  output  1  unit can accept an operand
in_value  input  DATA_WIDTH  operand
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_log  output  LOG_WIDTH  ceil(log2(in_value)), with 0 and 1 both giving 0
out_pow  output  DATA_WIDTH+1  2^out_log
out_exact  output  1  operand is an exact power of two (out_pow == operand), including 1; 0 for operand 0
done_count  output  16  number of completed output handshakes, wraps modulo 2^16

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state IDLE, in_ready 0 while rst is high, out_valid 0, out_log 0, out_pow 1, out_exact 0, done_count 0.
- in_ready = (state == IDLE) && !rst. It is combinational from the state register.
- IDLE:
  - in_valid && in_ready at a rising edge is an accept.
  - On accept: latch in_value into val, set pow=1 and exp=0, go to SEARCH.
- SEARCH, each cycle:
  - If pow >= val: register out_log=exp, out_pow=pow, out_exact=(pow==val); go to DONE.
  - Else: pow <= pow<<1 and exp <= exp+1; stay in SEARCH.
- DONE:
  - out_valid=1. Outputs stay stable while out_ready is 0.
  - On out_valid && out_ready: go to IDLE and increment done_count.
- Latency:
  - Result k has out_valid asserted k+1 cycles after the accept edge.
  - Operand 0 or 1: out_valid 1 cycle after accept.
  - Worst case, operand 2^(DATA_WIDTH-1)+1 .. 2^DATA_WIDTH-1: DATA_WIDTH+1 cycles.
- Width rules:
  - pow is DATA_WIDTH+1 bits, so doubling can never overflow before pow >= val.
  - The compare is unsigned, with val zero-extended by 1 bit.
- Throughput: no overlap. in_ready is 0 during SEARCH and DONE, and returns to 1 the cycle after the output handshake. Peak rate is one operation per k+3 cycles.
- in_valid while busy is ignored and in_value is not sampled. The source must hold in_valid until in_ready.
- out_ready while not out_valid has no effect.
- Reset mid-SEARCH or mid-DONE:
  - Aborts the operation; the result is discarded.
  - All outputs return to reset values on the next edge.
  - done_count is cleared.
- out_log/out_pow/out_exact keep their last result in IDLE. They are only meaningful while out_valid is 1.

Test Plan:
- Directed values, each with out_ready=1:
  - 0 -> log 0, pow 1, exact 0, latency 1
  - 1 -> 0, 1, exact 1, latency 1
  - 2 -> 1, 2, exact 1, latency 2
  - 3 -> 2, 4, exact 0, latency 3
  - 256 -> 8, 256, exact 1, latency 9
  - 257 -> 9, 512, exact 0, latency 10
  - 511 -> 9, 512, exact 0, latency 10
- Exhaustive sweep of in_value 0..511 from a free-running counter:
  - out_log matches $clog2 every result.
  - out_pow == 1<<out_log.
  - done_count ends at 512.
- Backpressure: operand 100, out_ready held 0 for 5 cycles after out_valid:
  - out_valid and the outputs (7, 128, 0) stay stable.
  - in_ready stays 0.
  - Handshake on cycle 6; in_ready is 1 the next cycle.
- Busy input: accept 300, then drive in_valid with 5 during SEARCH:
  - Only result 9/512 appears.
  - 5 is accepted only after returning to IDLE and gives 3/8.
- Reset: assert rst for 1 cycle, 4 cycles after accepting 400:
  - Next cycle out_valid=0, in_ready=0 while rst is high, done_count=0.
  - After rst, 400 -> 9/512 with normal latency 10.
- Reset in DONE with out_ready=0: result dropped, no handshake counted, done_count=0.

Source files
------------

// File: rtl/clog2_seq_unit_if.sv
// Operand/result handshake bundle for the ceil-log2 unit.
// The slave modport is the unit's view; the master modport is the client's view.
interface clog2_seq_unit_if #(
  parameter int DATA_WIDTH = 9,
  parameter int LOG_WIDTH  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_value;
  logic                  out_valid;
  logic                  out_ready;
  logic [LOG_WIDTH-1:0]  out_log;
  logic [DATA_WIDTH:0]   out_pow;
  logic                  out_exact;
  logic [15:0]           done_count;

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_log, out_pow, out_exact, done_count
  );

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_log, out_pow, out_exact, done_count
  );
endinterface

// File: rtl/clog2_seq_unit.sv
// Sequential ceil-log2: doubles a power of two from 1 until it covers the operand,
// then reports the exponent, the rounded-up power and whether the operand was exact.
module clog2_seq_unit #(
  parameter int DATA_WIDTH = 9,
  parameter int LOG_WIDTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  clog2_seq_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_val;
  logic [DATA_WIDTH:0]   r_pow;
  logic [LOG_WIDTH-1:0]  r_exp;
  logic [LOG_WIDTH-1:0]  r_res_log;
  logic [DATA_WIDTH:0]   r_res_pow;
  logic                  r_res_exact;
  logic [15:0]           r_done_count;

  logic                  w_accept;
  logic                  w_out_fire;
  logic                  w_covered;

  // pow carries one extra bit, so the doubling always reaches the operand without wrapping.
  assign w_covered = (r_pow >= {1'b0, r_val});

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_out_fire   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (w_covered) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_out_fire   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val        <= '0;
      r_pow        <= {{DATA_WIDTH{1'b0}}, 1'b1};
      r_exp        <= '0;
      r_res_log    <= '0;
      r_res_pow    <= {{DATA_WIDTH{1'b0}}, 1'b1};
      r_res_exact  <= 1'b0;
      r_done_count <= '0;
    end else begin
      if (w_accept) begin
        r_val <= bus.in_value;
        r_pow <= {{DATA_WIDTH{1'b0}}, 1'b1};
        r_exp <= '0;
      end
      if (r_state == S_SEARCH) begin
        if (w_covered) begin
          r_res_log   <= r_exp;
          r_res_pow   <= r_pow;
          r_res_exact <= (r_pow == {1'b0, r_val});
        end else begin
          r_pow <= r_pow << 1;
          r_exp <= r_exp + 1'b1;
        end
      end
      if (w_out_fire) begin
        r_done_count <= r_done_count + 16'd1;
      end
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE) && !rst;
  assign bus.out_valid  = (r_state == S_DONE);
  assign bus.out_log    = r_res_log;
  assign bus.out_pow    = r_res_pow;
  assign bus.out_exact  = r_res_exact;
  assign bus.done_count = r_done_count;

endmodule

// File: tb/tb_clog2_seq_unit.sv
// Directed and sweep bench for clog2_seq_unit; each task checks its own scenario.
module tb_clog2_seq_unit;

  localparam int DW = 9;
  localparam int LW = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  clog2_seq_unit_if #(.DATA_WIDTH(DW), .LOG_WIDTH(LW)) bus ();

  clog2_seq_unit #(.DATA_WIDTH(DW), .LOG_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents one operand for a single accept, then counts
  // edges until out_valid. Leaves the result pending; out_ready is the caller's.
  task automatic do_op(input int v, output int lat, output bit ok);
    int guard;
    ok    = 1'b1;
    lat   = 0;
    guard = 0;
    while (!bus.in_ready && guard < 40) begin
      step();
      guard++;
    end
    if (!bus.in_ready) begin
      ok = 1'b0;
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_value = v[DW-1:0];
    step();
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
    if (!bus.out_valid) ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready got %0b want 0", bus.in_ready);
    end
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid);
    end
    n_tests++;
    if (bus.out_log !== 4'd0 || bus.out_pow !== 10'd1 || bus.out_exact !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got log=%0d pow=%0d exact=%0b want 0/1/0",
               bus.out_log, bus.out_pow, bus.out_exact);
    end
    n_tests++;
    if (bus.done_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_done_count got %0d want 0", bus.done_count);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_in_ready got %0b want 1", bus.in_ready);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_directed();
    int vals[7]  = '{0, 1, 2, 3, 256, 257, 511};
    int logs[7]  = '{0, 0, 1, 2, 8, 9, 9};
    int pows[7]  = '{1, 1, 2, 4, 256, 512, 512};
    bit exs[7]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int lats[7]  = '{1, 1, 2, 3, 9, 10, 10};
    int lat;
    bit ok;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      do_op(vals[i], lat, ok);
      $display("[TB] directed in=%0d log=%0d pow=%0d exact=%0b lat=%0d",
               vals[i], bus.out_log, bus.out_pow, bus.out_exact, lat);
      n_tests++;
      if (!ok) begin
        n_fail++; $display("FAIL directed_timeout in=%0d got no result want result", vals[i]);
      end
      n_tests++;
      if (int'(bus.out_log) !== logs[i]) begin
        n_fail++; $display("FAIL directed_log in=%0d got %0d want %0d", vals[i], bus.out_log, logs[i]);
      end
      n_tests++;
      if (int'(bus.out_pow) !== pows[i]) begin
        n_fail++; $display("FAIL directed_pow in=%0d got %0d want %0d", vals[i], bus.out_pow, pows[i]);
      end
      n_tests++;
      if (bus.out_exact !== exs[i]) begin
        n_fail++; $display("FAIL directed_exact in=%0d got %0b want %0b", vals[i], bus.out_exact, exs[i]);
      end
      n_tests++;
      if (lat !== lats[i]) begin
        n_fail++; $display("FAIL directed_latency in=%0d got %0d want %0d", vals[i], lat, lats[i]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit ok;
    logic [15:0] dc0;
    bus.out_ready = 1'b0;
    dc0 = bus.done_count;
    do_op(100, lat, ok);
    n_tests++;
    if (!ok || lat !== 8) begin
      n_fail++; $display("FAIL bp_latency got %0d (ok=%0b) want 8", lat, ok);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_log !== 4'd7 || bus.out_pow !== 10'd128 ||
          bus.out_exact !== 1'b0 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got v=%0b log=%0d pow=%0d ex=%0b rdy=%0b want 1/7/128/0/0",
                 c, bus.out_valid, bus.out_log, bus.out_pow, bus.out_exact, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    step();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release got v=%0b rdy=%0b want 0/1", bus.out_valid, bus.in_ready);
    end
    n_tests++;
    if (bus.done_count !== dc0 + 16'd1) begin
      n_fail++; $display("FAIL bp_done_count got %0d want %0d", bus.done_count, dc0 + 16'd1);
    end
    $display("[TB] backpressure in=100 held 5 cycles");
  endtask

  task automatic test_busy_input();
    int lat;
    int guard;
    guard = 0;
    bus.out_ready = 1'b1;
    while (!bus.in_ready && guard < 40) begin
      step();
      guard++;
    end
    bus.in_valid = 1'b1;
    bus.in_value = 9'd300;
    step();
    bus.in_value = 9'd5;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
    n_tests++;
    if (bus.out_log !== 4'd9 || bus.out_pow !== 10'd512 || lat !== 10) begin
      n_fail++;
      $display("FAIL busy_first got log=%0d pow=%0d lat=%0d want 9/512/10", bus.out_log, bus.out_pow, lat);
    end
    step();
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL busy_idle got rdy=%0b v=%0b want 1/0", bus.in_ready, bus.out_valid);
    end
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
    n_tests++;
    if (bus.out_log !== 4'd3 || bus.out_pow !== 10'd8 || bus.out_exact !== 1'b0 || lat !== 4) begin
      n_fail++;
      $display("FAIL busy_second got log=%0d pow=%0d ex=%0b lat=%0d want 3/8/0/4",
               bus.out_log, bus.out_pow, bus.out_exact, lat);
    end
    step();
    $display("[TB] busy input 300 then 5 -> %0d/%0d", bus.out_log, bus.out_pow);
  endtask

  task automatic test_reset_search();
    int lat;
    bit ok;
    int guard;
    guard = 0;
    bus.out_ready = 1'b1;
    while (!bus.in_ready && guard < 40) begin
      step();
      guard++;
    end
    bus.in_valid = 1'b1;
    bus.in_value = 9'd400;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_search_in_ready got %0b want 0", bus.in_ready);
    end
    step();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.done_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_search_state got v=%0b rdy=%0b dc=%0d want 0/0/0",
               bus.out_valid, bus.in_ready, bus.done_count);
    end
    n_tests++;
    if (bus.out_log !== 4'd0 || bus.out_pow !== 10'd1 || bus.out_exact !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_search_outputs got %0d/%0d/%0b want 0/1/0", bus.out_log, bus.out_pow, bus.out_exact);
    end
    rst = 1'b0;
    do_op(400, lat, ok);
    n_tests++;
    if (!ok || bus.out_log !== 4'd9 || bus.out_pow !== 10'd512 || lat !== 10) begin
      n_fail++;
      $display("FAIL rst_search_rerun got log=%0d pow=%0d lat=%0d ok=%0b want 9/512/10",
               bus.out_log, bus.out_pow, lat, ok);
    end
    step();
    n_tests++;
    if (bus.done_count !== 16'd1) begin
      n_fail++; $display("FAIL rst_search_count got %0d want 1", bus.done_count);
    end
    $display("[TB] reset during search, rerun 400 -> %0d/%0d", bus.out_log, bus.out_pow);
  endtask

  task automatic test_reset_done();
    int lat;
    bit ok;
    bus.out_ready = 1'b0;
    do_op(6, lat, ok);
    n_tests++;
    if (!ok || bus.out_log !== 4'd3 || bus.out_pow !== 10'd8) begin
      n_fail++; $display("FAIL rst_done_setup got %0d/%0d ok=%0b want 3/8", bus.out_log, bus.out_pow, ok);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.done_count !== 16'd0) begin
      n_fail++; $display("FAIL rst_done_drop got v=%0b dc=%0d want 0/0", bus.out_valid, bus.done_count);
    end
    bus.out_ready = 1'b1;
    repeat (3) step();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.done_count !== 16'd0) begin
      n_fail++; $display("FAIL rst_done_nocount got v=%0b dc=%0d want 0/0", bus.out_valid, bus.done_count);
    end
    $display("[TB] reset during done, result dropped");
  endtask

  task automatic test_sweep();
    int lat;
    bit ok;
    int exp_log;
    bit exp_exact;
    logic [DW:0] exp_pow;
    logic [DW-1:0] cnt;
    cnt = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      do_op(int'(cnt), lat, ok);
      exp_log   = $clog2(int'(cnt));
      exp_pow   = (DW+1)'(1) << bus.out_log;
      exp_exact = (cnt != 0) && ((cnt & (cnt - 1'b1)) == 0);
      $display("[TB] sweep in=%0d log=%0d pow=%0d exact=%0b", cnt, bus.out_log, bus.out_pow, bus.out_exact);
      n_tests++;
      if (!ok || int'(bus.out_log) !== exp_log || lat !== exp_log + 1) begin
        n_fail++;
        $display("FAIL sweep_log in=%0d got %0d lat=%0d ok=%0b want %0d lat=%0d",
                 cnt, bus.out_log, lat, ok, exp_log, exp_log + 1);
      end
      n_tests++;
      if (bus.out_pow !== exp_pow) begin
        n_fail++; $display("FAIL sweep_pow in=%0d got %0d want %0d", cnt, bus.out_pow, exp_pow);
      end
      n_tests++;
      if (bus.out_exact !== exp_exact) begin
        n_fail++; $display("FAIL sweep_exact in=%0d got %0b want %0b", cnt, bus.out_exact, exp_exact);
      end
      step();
      cnt = cnt + 1'b1;
    end
    n_tests++;
    if (bus.done_count !== 16'd512) begin
      n_fail++; $display("FAIL sweep_done_count got %0d want 512", bus.done_count);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_busy_input();
    test_reset_search();
    test_reset_done();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
